// File: rtl/adcspi.sv
// adcspi: read-side SPI controller for the dual-channel LTC1407A-type ADC.
// A one-cycle request starts a conversion strobe on AD_CONV, then one
// 34-slot frame is shifted in from SPI_MISO on the shared SCK timing pulse.
// Both channel samples are published together with a one-cycle done pulse.
module adcspi #(
    parameter int LEAD_BITS = 2,
    parameter int DATA_BITS = 14,
    parameter int GAP_BITS  = 2,
    parameter int TAIL_BITS = 2
) (
    input  logic                 CLK50MHZ,
    input  logic                 RST,
    input  logic                 spi_sck_trig,
    input  logic                 SPI_MISO,
    output logic                 AD_CONV,
    input  logic                 adctrig,
    output logic                 adcbusy,
    output logic                 adcdone,
    output logic [DATA_BITS-1:0] ch0,
    output logic [DATA_BITS-1:0] ch1
);

    localparam int FRAME = LEAD_BITS + DATA_BITS + GAP_BITS + DATA_BITS + TAIL_BITS;
    localparam int CW    = $clog2(FRAME);

    // Frame slot boundaries, expressed in counter width
    localparam logic [CW-1:0] CH0_FIRST = CW'(LEAD_BITS);
    localparam logic [CW-1:0] CH0_LAST  = CW'(LEAD_BITS + DATA_BITS - 1);
    localparam logic [CW-1:0] CH1_FIRST = CW'(LEAD_BITS + DATA_BITS + GAP_BITS);
    localparam logic [CW-1:0] CH1_LAST  = CW'(LEAD_BITS + 2 * DATA_BITS + GAP_BITS - 1);
    localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAITCONV = 3'd1;
    localparam logic [2:0] ST_CONV     = 3'd2;
    localparam logic [2:0] ST_SHIFT    = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATA_BITS-1:0] sh0_q, sh0_d;
    logic [DATA_BITS-1:0] sh1_q, sh1_d;
    logic [DATA_BITS-1:0] ch0_q, ch0_d;
    logic [DATA_BITS-1:0] ch1_q, ch1_d;
    logic                 conv_q, conv_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Next-state logic: sequence request -> strobe -> frame shift -> publish
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        ch0_d   = ch0_q;
        ch1_d   = ch1_q;
        conv_d  = conv_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (adctrig) begin
                    state_d = ST_WAITCONV;
                    busy_d  = 1'b1;
                end
            end
            ST_WAITCONV: begin
                if (spi_sck_trig) begin
                    state_d = ST_CONV;
                    conv_d  = 1'b1;
                end
            end
            ST_CONV: begin
                if (spi_sck_trig) begin
                    state_d = ST_SHIFT;
                    conv_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (spi_sck_trig) begin
                    if (cnt_q >= CH0_FIRST && cnt_q <= CH0_LAST) begin
                        sh0_d = {sh0_q[DATA_BITS-2:0], SPI_MISO};
                    end else if (cnt_q >= CH1_FIRST && cnt_q <= CH1_LAST) begin
                        sh1_d = {sh1_q[DATA_BITS-2:0], SPI_MISO};
                    end
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        ch0_d   = sh0_d;
                        ch1_d   = sh1_d;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                conv_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset that also clears published samples
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            ch0_q   <= '0;
            ch1_q   <= '0;
            conv_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            ch0_q   <= ch0_d;
            ch1_q   <= ch1_d;
            conv_q  <= conv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign AD_CONV = conv_q;
    assign adcbusy = busy_q;
    assign adcdone = done_q;
    assign ch0     = ch0_q;
    assign ch1     = ch1_q;

endmodule

// File: tb/tb_adcspi.sv
// tb_adcspi: directed bench for adcspi with an event-counting reference model
// and a behavioural ADC that serialises a chosen pair of samples.
module tb_adcspi;

    localparam int FRAME      = 34;
    localparam int TRIG_DIV   = 4;
    localparam int DONE_LIMIT = 600;

    logic        CLK50MHZ = 1'b0;
    logic        RST = 1'b1;
    logic        spi_sck_trig = 1'b0;
    logic        SPI_MISO = 1'b0;
    logic        AD_CONV;
    logic        adctrig = 1'b0;
    logic        adcbusy;
    logic        adcdone;
    logic [13:0] ch0;
    logic [13:0] ch1;

    int checks = 0;
    int failures = 0;

    // ADC-side and generator state
    logic [FRAME-1:0] adc_frame = '0;
    int               adc_idx = FRAME;
    logic             conv_prev = 1'b0;
    logic             trig_en = 1'b1;
    int               trig_div = 0;

    // Reference model state
    logic        m_busy = 1'b0;
    logic        m_conv = 1'b0;
    logic        m_done = 1'b0;
    logic [13:0] m_ch0 = '0;
    logic [13:0] m_ch1 = '0;
    int          m_trigs = 0;
    logic        m_seen [0:FRAME-1];

    // Observation counters
    logic chk_en = 1'b0;
    int   conv_pulses = 0;
    int   done_pulses = 0;
    int   conv_len = 0;
    logic done_prev = 1'b0;
    logic conv_obs_prev = 1'b0;

    adcspi dut (
        .CLK50MHZ    (CLK50MHZ),
        .RST         (RST),
        .spi_sck_trig(spi_sck_trig),
        .SPI_MISO    (SPI_MISO),
        .AD_CONV     (AD_CONV),
        .adctrig     (adctrig),
        .adcbusy     (adcbusy),
        .adcdone     (adcdone),
        .ch0         (ch0),
        .ch1         (ch1)
    );

    // 50 MHz system clock
    always #10 CLK50MHZ = ~CLK50MHZ;

    // Frame slot i is the i-th bit on the wire; filler goes into lead/gap/tail
    function automatic logic [FRAME-1:0] mk_frame(input logic [13:0] a, input logic [13:0] b,
                                                 input logic fill);
        logic [FRAME-1:0] f;
        f = {FRAME{fill}};
        for (int i = 0; i < 14; i++) begin
            f[2 + i]  = a[13 - i];
            f[18 + i] = b[13 - i];
        end
        return f;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural ADC plus SCK trigger generator, both driven on the falling edge
    initial begin
        forever begin
            @(negedge CLK50MHZ);
            if (conv_prev && !AD_CONV) adc_idx = 0;
            else if (spi_sck_trig && adc_idx < FRAME) adc_idx++;
            conv_prev = AD_CONV;
            SPI_MISO = (adc_idx < FRAME) ? adc_frame[adc_idx] : 1'b0;
            if (trig_en) begin
                trig_div = (trig_div + 1) % TRIG_DIV;
                spi_sck_trig = (trig_div == 0);
            end else begin
                spi_sck_trig = 1'b0;
            end
        end
    end

    // Reference model: counts SCK pulses since acceptance and derives outputs from the frame rules
    always @(posedge CLK50MHZ) begin
        int t;
        logic [13:0] c0, c1;
        if (RST) begin
            m_busy  <= 1'b0;
            m_conv  <= 1'b0;
            m_done  <= 1'b0;
            m_ch0   <= '0;
            m_ch1   <= '0;
            m_trigs <= 0;
        end else if (!m_busy) begin
            m_done <= 1'b0;
            if (adctrig) begin
                m_busy  <= 1'b1;
                m_trigs <= 0;
            end
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (spi_sck_trig) begin
            t = m_trigs + 1;
            m_trigs <= t;
            if (t == 1) begin
                m_conv <= 1'b1;
            end else if (t == 2) begin
                m_conv <= 1'b0;
            end else begin
                m_seen[t - 3] <= SPI_MISO;
                if (t == FRAME + 2) begin
                    for (int i = 0; i < 14; i++) begin
                        c0[13 - i] = m_seen[2 + i];
                        c1[13 - i] = m_seen[18 + i];
                    end
                    m_ch0  <= c0;
                    m_ch1  <= c1;
                    m_done <= 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus pulse counting
    always @(negedge CLK50MHZ) begin
        if (chk_en) begin
            checkOutput("busy", adcbusy, m_busy);
            checkOutput("ad_conv", AD_CONV, m_conv);
            checkOutput("done", adcdone, m_done);
            checkOutput("ch0", ch0, m_ch0);
            checkOutput("ch1", ch1, m_ch1);
            if (AD_CONV && !conv_obs_prev) conv_pulses++;
            if (adcdone && !done_prev) done_pulses++;
            if (AD_CONV) conv_len++;
            if (!AD_CONV && conv_obs_prev) begin
                checkOutput("conv_width", conv_len, TRIG_DIV);
                conv_len = 0;
            end
            conv_obs_prev = AD_CONV;
            done_prev     = adcdone;
        end
    end

    // One-cycle conversion request
    task automatic applyStimulus();
        @(negedge CLK50MHZ); #2;
        adctrig = 1'b1;
        @(negedge CLK50MHZ); #2;
        adctrig = 1'b0;
    endtask

    // Request placed in the same cycle as an SCK trigger pulse
    task automatic request_on_trig();
        int n = 0;
        @(negedge CLK50MHZ); #2;
        while (spi_sck_trig !== 1'b1 && n < 20) begin
            @(negedge CLK50MHZ); #2;
            n++;
        end
        checkOutput("trig_align", spi_sck_trig, 1'b1);
        adctrig = 1'b1;
        @(negedge CLK50MHZ); #2;
        adctrig = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (adcdone !== 1'b1 && n < DONE_LIMIT) begin
            @(negedge CLK50MHZ); #2;
            n++;
        end
        checkOutput("wait_done", adcdone, 1'b1);
    endtask

    task automatic wait_trigs(input int target);
        int n = 0;
        while (m_trigs != target && n < DONE_LIMIT) begin
            @(negedge CLK50MHZ); #2;
            n++;
        end
        checkOutput("wait_trigs", m_trigs, target);
    endtask

    // Runs one frame and checks the published pair against literals
    task automatic run_frame(input string name, input logic [13:0] a, input logic [13:0] b,
                             input logic fill);
        adc_frame = mk_frame(a, b, fill);
        applyStimulus();
        wait_done();
        checkOutput({name, "_ch0"}, ch0, a);
        checkOutput({name, "_ch1"}, ch1, b);
    endtask

    initial begin
        int c0, d0;

        // Reset state
        repeat (3) @(negedge CLK50MHZ);
        #2;
        checkOutput("rst_busy", adcbusy, 1'b0);
        checkOutput("rst_conv", AD_CONV, 1'b0);
        checkOutput("rst_done", adcdone, 1'b0);
        checkOutput("rst_ch0", ch0, 14'h0000);
        checkOutput("rst_ch1", ch1, 14'h0000);
        RST = 1'b0;
        chk_en = 1'b1;

        // Basic frame, request coincident with a trigger pulse
        $display("[TB] basic frame");
        adc_frame = mk_frame(14'h1ABC, 14'h2345, 1'b0);
        c0 = conv_pulses;
        d0 = done_pulses;
        request_on_trig();
        wait_done();
        checkOutput("basic_ch0", ch0, 14'h1ABC);
        checkOutput("basic_ch1", ch1, 14'h2345);
        checkOutput("basic_busy_at_done", adcbusy, 1'b1);
        @(negedge CLK50MHZ); #2;
        checkOutput("basic_done_single", adcdone, 1'b0);
        checkOutput("basic_busy_after", adcbusy, 1'b0);
        checkOutput("basic_conv_pulses", conv_pulses - c0, 1);
        checkOutput("basic_done_pulses", done_pulses - d0, 1);

        // Boundary codes with filler slots driven high
        $display("[TB] boundary codes");
        run_frame("bnd1", 14'h3FFF, 14'h2000, 1'b1);
        run_frame("bnd2", 14'h0000, 14'h1FFF, 1'b1);

        // Requests while busy, including during the done cycle
        $display("[TB] busy rejection");
        adc_frame = mk_frame(14'h2468, 14'h1357, 1'b0);
        c0 = conv_pulses;
        d0 = done_pulses;
        applyStimulus();
        wait_trigs(12);
        adctrig = 1'b1;
        @(negedge CLK50MHZ); #2;
        adctrig = 1'b0;
        wait_done();
        adctrig = 1'b1;
        @(negedge CLK50MHZ); #2;
        adctrig = 1'b0;
        repeat (200) @(negedge CLK50MHZ);
        #2;
        checkOutput("rej_conv_pulses", conv_pulses - c0, 1);
        checkOutput("rej_done_pulses", done_pulses - d0, 1);
        checkOutput("rej_busy", adcbusy, 1'b0);
        checkOutput("rej_ch0", ch0, 14'h2468);
        checkOutput("rej_ch1", ch1, 14'h1357);

        // Back-to-back frames; first values held until the second done
        $display("[TB] back to back");
        run_frame("b2b1", 14'h0555, 14'h2AAA, 1'b0);
        adc_frame = mk_frame(14'h0123, 14'h3210, 1'b0);
        @(negedge CLK50MHZ); #2;
        checkOutput("b2b_done_low", adcdone, 1'b0);
        adctrig = 1'b1;
        @(negedge CLK50MHZ); #2;
        adctrig = 1'b0;
        checkOutput("b2b_busy", adcbusy, 1'b1);
        checkOutput("b2b_hold_ch0", ch0, 14'h0555);
        wait_done();
        checkOutput("b2b2_ch0", ch0, 14'h0123);
        checkOutput("b2b2_ch1", ch1, 14'h3210);

        // Reset mid-frame at shift index 20
        $display("[TB] reset mid frame");
        adc_frame = mk_frame(14'h0F0F, 14'h3C3C, 1'b0);
        d0 = done_pulses;
        applyStimulus();
        wait_trigs(22);
        RST = 1'b1;
        @(negedge CLK50MHZ); #2;
        RST = 1'b0;
        checkOutput("mid_rst_busy", adcbusy, 1'b0);
        checkOutput("mid_rst_conv", AD_CONV, 1'b0);
        checkOutput("mid_rst_ch0", ch0, 14'h0000);
        checkOutput("mid_rst_ch1", ch1, 14'h0000);
        repeat (200) @(negedge CLK50MHZ);
        #2;
        checkOutput("mid_rst_no_done", done_pulses - d0, 0);
        run_frame("post_rst", 14'h1234, 14'h0ABC, 1'b0);

        // Stalled SCK after acceptance
        $display("[TB] stalled sck");
        trig_en = 1'b0;
        adc_frame = mk_frame(14'h2BAD, 14'h0FED, 1'b1);
        applyStimulus();
        repeat (200) @(negedge CLK50MHZ);
        #2;
        checkOutput("stall_busy", adcbusy, 1'b1);
        checkOutput("stall_conv", AD_CONV, 1'b0);
        trig_en = 1'b1;
        wait_done();
        checkOutput("stall_ch0", ch0, 14'h2BAD);
        checkOutput("stall_ch1", ch1, 14'h0FED);

        repeat (4) @(negedge CLK50MHZ);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/adcspi.md
Name: adcspi

Overview:
- SPI read-side controller for the board's dual-channel LTC1407A-type ADC. It is the receiving counterpart of the DAC write path.
- Shares the board SPI clock generator (`spisck`) and its `spi_sck_trig` timing pulse.
- On a one-cycle request from FPGA logic, it pulses `AD_CONV`, then shifts in one 34-bit ADC frame from `SPI_MISO`.
- It returns two 14-bit two's-complement samples and signals completion with a one-cycle done pulse.

Parameters:
- LEAD_BITS, 2, high-Z/ignored bit slots before channel 0 data.
- DATA_BITS, 14, bits per channel sample, MSB first.
- GAP_BITS, 2, ignored bit slots between channel 0 and channel 1.
- TAIL_BITS, 2, ignored bit slots after channel 1. Frame length FRAME = LEAD+DATA+GAP+DATA+TAIL = 34.

Ports:
- CLK50MHZ  in  1  system clock, 50 MHz; all logic on its rising edge.
- RST  in  1  reset, synchronous, active-high.
- spi_sck_trig  in  1  one-CLK50MHZ-cycle pulse per SPI_SCK period, asserted in the cycle before the SPI_SCK rising edge.
- SPI_MISO  in  1  serial data from the ADC.
- AD_CONV  out  1  conversion start strobe to the ADC.
- adctrig  in  1  one-cycle request to start a conversion.
- adcbusy  out  1  high from request acceptance until adcdone, inclusive.
- adcdone  out  1  one-cycle completion pulse.
- ch0  out  DATA_BITS  last channel 0 sample, two's complement.
- ch1  out  DATA_BITS  last channel 1 sample, two's complement.

Behaviour:
- Reset: on RST high at a clock edge, the block goes to IDLE.
  - AD_CONV=0, adcbusy=0, adcdone=0, ch0=0, ch1=0.
  - Bit counter and shift registers are cleared.
  - RST has priority over every other input.
- FSM states: IDLE, WAITCONV, CONV, SHIFT, DONE.
- IDLE: adctrig=1 → WAITCONV and adcbusy=1 on the next edge. Otherwise the block stays in IDLE.
- WAITCONV: on the first spi_sck_trig → CONV, AD_CONV<=1.
- CONV: on the next spi_sck_trig → SHIFT, AD_CONV<=0, bit counter<=0. AD_CONV is therefore high for exactly one SCK period.
- SHIFT: on each spi_sck_trig, SPI_MISO is sampled as frame bit index = counter, then the counter increments.
  - Indices 0..1 are discarded.
  - Indices 2..15 shift into the ch0 shadow register, MSB first.
  - Indices 16..17 are discarded.
  - Indices 18..31 shift into the ch1 shadow register, MSB first.
  - Indices 32..33 are discarded.
  - After sampling index FRAME-1 → DONE.
- DONE: lasts one cycle.
  - adcdone=1; ch0/ch1 are loaded from the shadow registers in the same edge, so they change atomically.
  - adcbusy returns to 0 on the following edge → IDLE.
- Latency: adcdone rises the CLK50MHZ cycle after the (FRAME+2)th spi_sck_trig following acceptance, i.e. the 36th trig pulse.
- ch0/ch1 hold their value between conversions. They never show partial frames.
- adctrig outside IDLE, including during DONE, is ignored. It is not queued.
- adctrig and spi_sck_trig in the same IDLE cycle: the request is accepted, but that trig pulse does not count. The first counted trig is the next one.
- No spi_sck_trig: the block waits indefinitely in WAITCONV or SHIFT, with adcbusy held high.
- RST in mid-frame: the block aborts to IDLE. No adcdone is produced, AD_CONV drops on that edge, and ch0/ch1 are cleared.
- Counter width: ceil(log2(FRAME)) bits; it never wraps within a frame.

Test Plan:
- Basic frame: the behavioural ADC model returns ch0=14'h1ABC and ch1=14'h2345.
  - AD_CONV must be high for exactly one SCK period.
  - adcdone must be a single pulse on the cycle after the 36th trig pulse.
  - ch0=1ABC and ch1=2345 must appear in the same cycle, with adcbusy high throughout.
- Boundary codes: model returns ch0=14'h3FFF and ch1=14'h2000, then ch0=14'h0000 and ch1=14'h1FFF.
  - Exact values must be captured.
  - Lead, gap and tail bits driven to 1 must not leak into the samples.
- Busy rejection: pulse adctrig again at SHIFT index 10 and during DONE.
  - Exactly one AD_CONV pulse and one adcdone must result, with no second frame.
- Back-to-back: assert adctrig in the cycle after adcdone deasserts.
  - A second full frame must run.
  - ch0/ch1 must hold the first values until the second adcdone, then update to 0123/3210.
- Reset mid-frame: assert RST for one cycle at SHIFT index 20.
  - The block must return to IDLE with AD_CONV=0, adcbusy=0, ch0=ch1=0 and no adcdone.
  - A following adctrig must complete normally.
- Stalled SCK: hold spi_sck_trig low for 200 cycles after acceptance.
  - adcbusy must stay 1 and AD_CONV must stay 0.
  - Once pulses resume, the frame must complete correctly.
